// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Generates the load enables and bubble controls for the PC and the four pipeline registers.
// It tracks a valid bit per stage, runs a memory-wait watchdog and keeps two saturating
// performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rd,
  input  logic              ex_redirect,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              halt_req,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_mem_en,
  output logic              mem_wb_flush,
  output logic              halted,
  output logic              mem_timeout,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e            state_q, state_d;
  logic [3:0]        v_q, v_d;  // IF/ID, ID/EX, EX/MEM, MEM/WB
  logic [WaitW-1:0]  wait_q, wait_d, wait_inc;
  logic              mem_timeout_q, mem_timeout_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  logic redir, load_use, mstall, fetch, rule_redir;

  assign redir    = ex_redirect & v_q[1];
  assign load_use = ex_mem_read & (ex_rd != 5'd0) & v_q[0] &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign mstall   = mem_req & ~mem_ready;

  // Pipeline control outputs, decoded by priority from state and hazard terms.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_flush = 1'b0;
    halted       = 1'b0;
    rule_redir   = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StRun, StDrain: begin
          if (mstall) begin
            mem_wb_flush = 1'b1;
          end else if (redir) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            rule_redir  = 1'b1;
          end else if (load_use) begin
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
          end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
          end
          // Draining: stop fetching new work but still follow a redirect target.
          if (state_q == StDrain) begin
            if_id_flush = 1'b1;
            pc_en       = redir & ~mstall;
          end
        end
        StHalted: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign fetch = pc_en & (state_q == StRun);

  // Next-state for the FSM, valid shadow, watchdog and counters.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (halt_req) state_d = StDrain;
      StDrain: begin
        if (!halt_req)                     state_d = StRun;
        else if (v_q == 4'd0 && !mstall)   state_d = StHalted;
      end
      StHalted: if (!halt_req) state_d = StRun;
      default:  state_d = StRun;
    endcase

    v_d = v_q;
    if (if_id_en)  v_d[0] = if_id_flush ? 1'b0 : fetch;
    if (id_ex_en)  v_d[1] = id_ex_flush ? 1'b0 : v_q[0];
    if (ex_mem_en) v_d[2] = v_q[1];
    v_d[3] = mem_wb_flush ? 1'b0 : v_q[2];

    wait_inc      = wait_q + 1'b1;
    wait_d        = '0;
    mem_timeout_d = mem_timeout_q;
    if (mstall) begin
      wait_d = (wait_q == WaitMax) ? wait_q : wait_inc;
      if (wait_q != WaitMax && wait_inc == WaitMax) mem_timeout_d = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (state_q == StRun && !pc_en && rst_n && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    flush_cnt_d = flush_cnt_q;
    if (rule_redir && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StRun;
      v_q           <= '0;
      wait_q        <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      v_q           <= v_d;
      wait_q        <= wait_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
